// File: rtl/jtag_driver.sv
// JTAG master: turns TLR_RESET / IDLE / SHIFT_IR / SHIFT_DR commands into TCK/TMS/TDI
// waveforms and returns the captured TDO bits through a valid/ready response.
module jtag_driver #(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned MAX_LEN = 32
) (
    input  logic               clk,
    input  logic               trst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [5:0]         cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               rsp_err,
    output logic               tck_o,
    output logic               tms_o,
    output logic               tdi_o,
    input  logic               tdo_i
);

    localparam int unsigned CntW = ($clog2(MAX_LEN + 1) > 6) ? $clog2(MAX_LEN + 1) : 6;
    localparam logic [1:0] OpTlr  = 2'd0;
    localparam logic [1:0] OpIdle = 2'd1;
    localparam logic [1:0] OpIr   = 2'd2;
    localparam logic [1:0] OpDr   = 2'd3;

    typedef enum logic [2:0] {StIdle, StPre, StShift, StPost, StResp} state_e;

    state_e             state_q, state_d;
    logic [7:0]         div_q, div_d;
    logic               tck_q, tck_d, tms_q, tms_d, tdi_q, tdi_d;
    logic [CntW-1:0]    step_q, step_d, len_q, len_d;
    logic [1:0]         op_q, op_d;
    logic [MAX_LEN-1:0] data_q, data_d, rsp_data_q, rsp_data_d, dat_sh;
    logic [15:0]        pat_q, pat_d, pat_sh;
    logic [3:0]         plen_q, plen_d;
    logic               rsp_err_q, rsp_err_d, synced_q, synced_d, alive_q;
    logic               running, half_end, rise, fall, need_tlr;

    assign cmd_ready = (state_q == StIdle) && alive_q;
    assign rsp_valid = (state_q == StResp);
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign tck_o     = tck_q;
    assign tms_o     = tms_q;
    assign tdi_o     = tdi_q;

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        tck_d      = tck_q;
        step_d     = step_q;
        op_d       = op_q;
        len_d      = len_q;
        data_d     = data_q;
        pat_d      = pat_q;
        plen_d     = plen_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        synced_d   = synced_q;
        need_tlr   = 1'b0;

        running  = (state_q == StPre) || (state_q == StShift) || (state_q == StPost);
        half_end = running && (div_q == 8'(CLK_DIV - 1));
        rise     = half_end && !tck_q;
        fall     = half_end && tck_q;

        if (running) begin
            div_d = half_end ? 8'd0 : div_q + 8'd1;
            if (half_end) tck_d = !tck_q;
        end

        if (rise && (state_q == StShift) && op_q[1]) begin
            rsp_data_d = rsp_data_q | ({{(MAX_LEN - 1){1'b0}}, tdo_i} << step_q);
        end

        unique case (state_q)
            StIdle: begin
                if (cmd_valid && cmd_ready) begin
                    op_d       = cmd_op;
                    len_d      = CntW'(cmd_len);
                    data_d     = cmd_data;
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b0;
                    step_d     = '0;
                    div_d      = 8'd0;
                    tck_d      = 1'b0;
                    need_tlr   = (cmd_op == OpTlr) || !synced_q;
                    // PRE TMS path, LSB first: optional TLR prefix, then the IR/DR entry path
                    pat_d      = need_tlr ? 16'h001f : 16'h0000;
                    plen_d     = need_tlr ? 4'd6 : 4'd0;
                    if (cmd_op == OpDr) begin
                        pat_d  = pat_d | (16'h0001 << plen_d);
                        plen_d = plen_d + 4'd3;
                    end else if (cmd_op == OpIr) begin
                        pat_d  = pat_d | (16'h0003 << plen_d);
                        plen_d = plen_d + 4'd4;
                    end
                    if (cmd_op[1] && ((cmd_len == 6'd0) || (32'(cmd_len) > MAX_LEN))) begin
                        rsp_err_d = 1'b1;
                        state_d   = StResp;
                    end else if ((cmd_op == OpIdle) && (cmd_len == 6'd0)) begin
                        state_d = StResp;
                    end else begin
                        synced_d = 1'b1;
                        state_d  = (plen_d == 4'd0) ? StShift : StPre;
                    end
                end
            end
            StPre: begin
                if (fall) begin
                    if (step_q == CntW'(plen_q) - CntW'(1)) begin
                        step_d  = '0;
                        state_d = (op_q == OpTlr) ? StResp : StShift;
                    end else begin
                        step_d = step_q + CntW'(1);
                    end
                end
            end
            StShift: begin
                if (fall) begin
                    if (step_q == len_q - CntW'(1)) begin
                        step_d  = '0;
                        state_d = op_q[1] ? StPost : StResp;
                    end else begin
                        step_d = step_q + CntW'(1);
                    end
                end
            end
            StPost: begin
                if (fall) begin
                    if (step_q == CntW'(1)) begin
                        step_d  = '0;
                        state_d = StResp;
                    end else begin
                        step_d = step_q + CntW'(1);
                    end
                end
            end
            StResp: begin
                if (rsp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // TMS/TDI follow the next step, so they only move when TCK falls or is parked
        pat_sh = pat_d >> step_d;
        dat_sh = data_d >> step_d;
        tms_d  = 1'b1;
        tdi_d  = 1'b0;
        unique case (state_d)
            StPre:   tms_d = pat_sh[0];
            StShift: begin
                tms_d = op_d[1] && (step_d == len_d - CntW'(1));
                tdi_d = op_d[1] && dat_sh[0];
            end
            StPost:  tms_d = (step_d == '0);
            default: tms_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!trst) begin
            state_q    <= StIdle;
            div_q      <= 8'd0;
            tck_q      <= 1'b0;
            tms_q      <= 1'b1;
            tdi_q      <= 1'b0;
            step_q     <= '0;
            len_q      <= '0;
            op_q       <= OpTlr;
            data_q     <= '0;
            pat_q      <= '0;
            plen_q     <= 4'd0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            synced_q   <= 1'b0;
            alive_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            tck_q      <= tck_d;
            tms_q      <= tms_d;
            tdi_q      <= tdi_d;
            step_q     <= step_d;
            len_q      <= len_d;
            op_q       <= op_d;
            data_q     <= data_d;
            pat_q      <= pat_d;
            plen_q     <= plen_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            synced_q   <= synced_d;
            alive_q    <= 1'b1;
        end
    end

endmodule

// File: tb/tb_jtag_driver.sv
// Directed bench for jtag_driver: drives commands against a behavioural TAP and checks
// TCK counts, TMS traces, captured TDO data, errors, handshakes and reset behaviour.
module tb_jtag_driver;

    localparam int unsigned Div    = 3;
    localparam int unsigned MaxLen = 32;
    localparam logic [31:0] Idcode = 32'h1234_5679;

    localparam int TTlr = 0, TRti = 1, TSelDr = 2, TCapDr = 3, TShDr = 4, TEx1Dr = 5;
    localparam int TPauDr = 6, TEx2Dr = 7, TUpdDr = 8, TSelIr = 9, TCapIr = 10, TShIr = 11;
    localparam int TEx1Ir = 12, TPauIr = 13, TEx2Ir = 14, TUpdIr = 15;

    logic              clk = 1'b0;
    logic              trst = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [1:0]        cmd_op = 2'd0;
    logic [5:0]        cmd_len = 6'd0;
    logic [MaxLen-1:0] cmd_data = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [MaxLen-1:0] rsp_data;
    logic              rsp_err;
    logic              tck_o, tms_o, tdi_o;
    logic              tdo = 1'b0;

    int     n_tests = 0;
    int     n_fail = 0;
    int     tck_rises = 0;
    bit     tms_log[$];
    longint rise_t[$];
    int     hi_run = 0;
    int     hi_bad = 0;
    int     edge_viol = 0;
    logic   prev_tms = 1'b1;
    logic   prev_tdi = 1'b0;

    int          tap_st = TRti;
    logic [31:0] dr_sr = '0;
    logic [3:0]  ir_sr = '0;
    logic [3:0]  tap_ir = '0;

    jtag_driver #(.CLK_DIV(Div), .MAX_LEN(MaxLen)) u_dut (
        .clk       (clk),
        .trst      (trst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_len   (cmd_len),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .tck_o     (tck_o),
        .tms_o     (tms_o),
        .tdi_o     (tdi_o),
        .tdo_i     (tdo)
    );

    always #5 clk = ~clk;

    function automatic int tap_next(input int s, input logic m);
        case (s)
            TTlr:    return m ? TTlr : TRti;
            TRti:    return m ? TSelDr : TRti;
            TSelDr:  return m ? TSelIr : TCapDr;
            TCapDr:  return m ? TEx1Dr : TShDr;
            TShDr:   return m ? TEx1Dr : TShDr;
            TEx1Dr:  return m ? TUpdDr : TPauDr;
            TPauDr:  return m ? TEx2Dr : TPauDr;
            TEx2Dr:  return m ? TUpdDr : TShDr;
            TUpdDr:  return m ? TSelDr : TRti;
            TSelIr:  return m ? TTlr : TCapIr;
            TCapIr:  return m ? TEx1Ir : TShIr;
            TShIr:   return m ? TEx1Ir : TShIr;
            TEx1Ir:  return m ? TUpdIr : TPauIr;
            TPauIr:  return m ? TEx2Ir : TPauIr;
            TEx2Ir:  return m ? TUpdIr : TShIr;
            default: return m ? TSelDr : TRti;
        endcase
    endfunction

    // Behavioural TAP: acts on rising TCK, drives TDO on falling TCK
    always @(posedge tck_o) begin
        tck_rises++;
        tms_log.push_back(tms_o);
        rise_t.push_back($time);
        case (tap_st)
            TCapDr:  dr_sr = Idcode;
            TShDr:   dr_sr = {tdi_o, dr_sr[31:1]};
            TCapIr:  ir_sr = 4'b0001;
            TShIr:   ir_sr = {tdi_o, ir_sr[3:1]};
            TUpdIr:  tap_ir = ir_sr;
            default: ;
        endcase
        tap_st = tap_next(tap_st, tms_o);
    end

    always @(negedge tck_o) begin
        if (tap_st == TShDr) tdo = dr_sr[0];
        else if (tap_st == TShIr) tdo = ir_sr[0];
    end

    always @(posedge clk) begin
        #2;
        if (tck_o && ((tms_o !== prev_tms) || (tdi_o !== prev_tdi))) edge_viol++;
        prev_tms = tms_o;
        prev_tdi = tdi_o;
        if (!trst) hi_run = 0;
        else if (tck_o) hi_run++;
        else if (hi_run != 0) begin
            if (hi_run != Div) hi_bad++;
            hi_run = 0;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [5:0] len, input logic [31:0] data);
        int n = 0;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("cmd_ready_wait", {63'd0, cmd_ready}, 64'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_len   = len;
        cmd_data  = data;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_len   = 6'd63;
        cmd_data  = '1;
    endtask

    task automatic wait_rsp(input string tag);
        int n = 0;
        while (!rsp_valid && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(tag, {63'd0, rsp_valid}, 64'd1);
    endtask

    task automatic take_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    function automatic logic [63:0] pack_tms(input int n);
        logic [63:0] v = '0;
        for (int i = 0; i < n && i < tms_log.size(); i++) v[i] = tms_log[i];
        return v;
    endfunction

    initial begin
        int r0;
        int busy_rdy;
        int n;
        logic [31:0] held;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", {63'd0, cmd_ready}, 64'd0);
        check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("rst_rsp_err", {63'd0, rsp_err}, 64'd0);
        check("rst_rsp_data", {32'd0, rsp_data}, 64'd0);
        check("rst_tck", {63'd0, tck_o}, 64'd0);
        check("rst_tms", {63'd0, tms_o}, 64'd1);
        check("rst_tdi", {63'd0, tdi_o}, 64'd0);
        trst = 1'b1;
        @(negedge clk);
        check("rdy_after_rst", {63'd0, cmd_ready}, 64'd1);

        // rsp_ready with no response pending is ignored
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        rsp_ready = 1'b0;
        check("stray_rsp_ready_valid", {63'd0, rsp_valid}, 64'd0);
        check("stray_rsp_ready_rdy", {63'd0, cmd_ready}, 64'd1);

        // IDCODE read: automatic TLR, then DR path
        r0 = tck_rises;
        tms_log.delete();
        send(2'd3, 6'd32, 32'hA5A5_0F0F);
        wait_rsp("idcode_rsp_timeout");
        check("idcode_data", {32'd0, rsp_data}, {32'd0, Idcode});
        check("idcode_err", {63'd0, rsp_err}, 64'd0);
        check("idcode_tck_count", 64'(tck_rises - r0), 64'd43);
        check("idcode_pre_tms", pack_tms(9), 64'h05F);
        check("idcode_tdi_shifted", {32'd0, dr_sr}, 64'hA5A5_0F0F);
        check("idcode_tap_rti", 64'(tap_st), 64'(TRti));
        take_rsp();

        // IR shift
        r0 = tck_rises;
        tms_log.delete();
        send(2'd2, 6'd4, 32'h2);
        wait_rsp("ir_rsp_timeout");
        check("ir_tck_count", 64'(tck_rises - r0), 64'd10);
        check("ir_tms_trace", pack_tms(10), 64'h183);
        check("ir_capture", {32'd0, rsp_data}, 64'h1);
        check("ir_err", {63'd0, rsp_err}, 64'd0);
        check("ir_tap_rti", 64'(tap_st), 64'(TRti));
        check("ir_tap_ir", {60'd0, tap_ir}, 64'h2);
        take_rsp();

        // Response held back for 20 cycles
        send(2'd3, 6'd8, 32'h3C);
        wait_rsp("hold_rsp_timeout");
        held = rsp_data;
        check("hold_first_data", {32'd0, held}, 64'h79);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("hold_valid", {63'd0, rsp_valid}, 64'd1);
            check("hold_data", {32'd0, rsp_data}, 64'h79);
            check("hold_cmd_ready", {63'd0, cmd_ready}, 64'd0);
            check("hold_tck", {63'd0, tck_o}, 64'd0);
        end
        take_rsp();
        check("hold_released_valid", {63'd0, rsp_valid}, 64'd0);
        check("hold_released_rdy", {63'd0, cmd_ready}, 64'd1);

        // Illegal lengths
        r0 = tck_rises;
        send(2'd3, 6'd0, 32'hFFFF_FFFF);
        wait_rsp("len0_rsp_timeout");
        check("len0_err", {63'd0, rsp_err}, 64'd1);
        check("len0_data", {32'd0, rsp_data}, 64'd0);
        check("len0_tck", 64'(tck_rises - r0), 64'd0);
        take_rsp();
        send(2'd2, 6'd33, 32'hFFFF_FFFF);
        wait_rsp("len33_rsp_timeout");
        check("len33_err", {63'd0, rsp_err}, 64'd1);
        check("len33_data", {32'd0, rsp_data}, 64'd0);
        check("len33_tck", 64'(tck_rises - r0), 64'd0);
        take_rsp();

        // IDLE clocks: 5 pulses of 2*Div cycles, TMS low
        r0 = tck_rises;
        tms_log.delete();
        rise_t.delete();
        send(2'd1, 6'd5, 32'h0);
        busy_rdy = 0;
        n = 0;
        while (!rsp_valid && n < 500) begin
            if (cmd_ready) busy_rdy++;
            @(negedge clk);
            n++;
        end
        check("idle_rsp_timeout", {63'd0, rsp_valid}, 64'd1);
        check("idle_busy_ready", 64'(busy_rdy), 64'd0);
        check("idle_tck_count", 64'(tck_rises - r0), 64'd5);
        check("idle_tms_low", pack_tms(5), 64'd0);
        check("idle_err", {63'd0, rsp_err}, 64'd0);
        for (int i = 1; i < rise_t.size(); i++) begin
            check("idle_period", 64'(rise_t[i] - rise_t[i-1]), 64'd60);
        end
        check("idle_rdy_before_take", {63'd0, cmd_ready}, 64'd0);
        take_rsp();
        check("tck_high_width", 64'(hi_bad), 64'd0);

        // Reset during bit 10 of a 32-bit DR shift
        r0 = tck_rises;
        send(2'd3, 6'd32, 32'hDEAD_BEEF);
        n = 0;
        while ((tck_rises - r0) < 14 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("bit10_reached", 64'(tck_rises - r0), 64'd14);
        trst = 1'b0;
        @(negedge clk);
        check("abort_cmd_ready", {63'd0, cmd_ready}, 64'd0);
        check("abort_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("abort_rsp_err", {63'd0, rsp_err}, 64'd0);
        check("abort_rsp_data", {32'd0, rsp_data}, 64'd0);
        check("abort_tck", {63'd0, tck_o}, 64'd0);
        check("abort_tms", {63'd0, tms_o}, 64'd1);
        check("abort_tdi", {63'd0, tdi_o}, 64'd0);
        trst = 1'b1;
        r0 = tck_rises;
        busy_rdy = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid) busy_rdy++;
        end
        check("abort_no_rsp", 64'(busy_rdy), 64'd0);
        check("abort_no_tck", 64'(tck_rises - r0), 64'd0);

        tms_log.delete();
        send(2'd3, 6'd32, 32'h0F0F_A5A5);
        wait_rsp("resync_rsp_timeout");
        check("resync_tlr_tms", pack_tms(6), 64'h1F);
        check("resync_tck_count", 64'(tck_rises - r0), 64'd43);
        check("resync_data", {32'd0, rsp_data}, {32'd0, Idcode});
        check("resync_tap_rti", 64'(tap_st), 64'(TRti));
        take_rsp();

        check("tms_tdi_stable_while_tck_high", 64'(edge_viol), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/jtag_driver.md
JTAG_DRIVER -- requirements
Module: jtag_driver

Interface
REQ-001 Parameter: CLK_DIV, default 2, clk cycles per TCK half-period (legal range 1..255).
REQ-002 Parameter: MAX_LEN, default 32, maximum shift length in bits.
REQ-003 clk  in  1  system clock; all logic on rising edge.
REQ-004 trst  in  1  reset, synchronous, active-low.
REQ-005 cmd_valid  in  1  command offered.
REQ-006 cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
REQ-007 cmd_op  in  2  operation: 0 TLR_RESET, 1 IDLE, 2 SHIFT_IR, 3 SHIFT_DR.
REQ-008 cmd_len  in  6  bit count (SHIFT ops) or TCK count (IDLE).
REQ-009 cmd_data  in  MAX_LEN  TDI data; LSB shifted first.
REQ-010 rsp_valid  out  1  response available; held until accepted.
REQ-011 rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
REQ-012 rsp_data  out  MAX_LEN  captured TDO bits.
REQ-013 rsp_err  out  1  command rejected, illegal length.
REQ-014 tck_o, tms_o, tdi_o  out  1 each  to TAP tck/tms/tdi.
REQ-015 tdo_i  in  1  from TAP tdo.

Function
REQ-016 The block SHALL divide clk so that each TCK period is 2*CLK_DIV clk cycles. tck_o SHALL idle low and toggle only while a command is executing.
REQ-017 tms_o and tdi_o SHALL change only in the clk cycle in which tck_o falls, or while tck_o is idle.
REQ-018 tdo_i SHALL be sampled in the clk cycle in which tck_o rises.
REQ-019 FSM states: IDLE, PRE (TMS path in), SHIFT, POST (TMS path out), RESP.
REQ-020 cmd_ready SHALL be 1 only in IDLE with rsp_valid=0.
REQ-021 cmd_op, cmd_len and cmd_data SHALL be registered on acceptance. Inputs SHALL be ignored at all other times.
REQ-022 The block SHALL assume the TAP starts in Run-Test/Idle and SHALL leave it in Run-Test/Idle after every command.
REQ-023 TLR_RESET SHALL produce 5 TCK with TMS=1, then 1 TCK with TMS=0, ignoring cmd_len. It sets the synced flag.
REQ-024 IDLE SHALL produce cmd_len TCK with TMS=0. cmd_len=0 produces 0 TCK and goes directly to RESP.
REQ-025 SHIFT_DR PRE TMS sequence SHALL be 1,0,0.
REQ-026 SHIFT_IR PRE TMS sequence SHALL be 1,1,0,0.
REQ-027 SHIFT SHALL produce cmd_len TCK with tdi_o = cmd_data[i] on bit i. TMS SHALL be 0, except 1 on the final bit (Exit1).
REQ-028 POST TMS sequence SHALL be 1 (Update), 0 (Run-Test/Idle).
REQ-029 The TDO sample on the rising TCK of shift bit i SHALL be stored in rsp_data[i]. Bits >= cmd_len SHALL be 0.
REQ-030 Legal SHIFT lengths are 1..MAX_LEN. Length 0 or >MAX_LEN SHALL produce 0 TCK, rsp_err=1 and rsp_data=0.
REQ-031 A SHIFT or IDLE accepted while synced=0 SHALL first execute the full TLR_RESET sequence, then the command with no extra gap.
REQ-032 On entering RESP: rsp_valid=1, tck_o low, rsp_err=0 except per REQ-030.
REQ-033 rsp_valid SHALL stay 1, with rsp_data and rsp_err stable, until rsp_ready=1. The FSM then returns to IDLE.
REQ-034 rsp_ready while rsp_valid=0 SHALL be ignored.
REQ-035 Bit and step counters SHALL be sized for MAX_LEN. No wrap SHALL occur for any legal length.

Reset
REQ-036 When trst=0 at a rising clk, the next cycle SHALL show: FSM=IDLE, synced=0, cmd_ready=0, rsp_valid=0, rsp_err=0, rsp_data=0, tck_o=0, tms_o=1, tdi_o=0.
REQ-037 cmd_ready SHALL go to 1 on the first cycle after trst returns to 1.
REQ-038 Reset mid-command SHALL abort the command, discard partial TDO and produce no response.
REQ-039 After reset mid-command, the next SHIFT or IDLE SHALL be preceded by TLR_RESET (synced=0).

Verification
REQ-040 Scenario: reset, then SHIFT_DR len=32 with a TAP model loaded with IDCODE 0x1234_5679. Required: auto TLR_RESET (6 TCK), then 3+32+2 TCK; rsp_data=0x1234_5679, rsp_err=0.
REQ-041 Scenario: SHIFT_IR len=4 data=0x2 against the TAP model. Required: TMS trace 1,1,0,0,0,0,0,1,1,0; rsp_data[3:0] = IR capture 0b0001; TAP ends in Run-Test/Idle.
REQ-042 Scenario: SHIFT_DR len=0, then a second command with len=33. Required: 0 TCK edges on each; rsp_err=1 and rsp_data=0 on both.
REQ-043 Scenario: CLK_DIV=3, IDLE len=5. Required: exactly 5 TCK pulses, each 6 clk cycles, TMS=0 throughout; cmd_ready=0 until the response is accepted.
REQ-044 Scenario: hold rsp_ready=0 for 20 cycles after a SHIFT_DR. Required: rsp_valid and rsp_data stable, cmd_ready=0, tck_o=0; the handshake completes on the first rsp_ready=1.
REQ-045 Scenario: assert trst=0 during bit 10 of a 32-bit SHIFT_DR. Required: REQ-036 values next cycle and no rsp_valid; the next SHIFT_DR starts with 5 TMS=1 TCK.
